// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop on a
// 16x sample tick, hands the mid-start sample to an external checker.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  rx_in,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic                  start_chk_en,
    output logic                  start_chk_bit,
    input  logic                  start_bit_error,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        START_CHK,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  pen_q, pen_d;
    logic                  podd_q, podd_d;
    logic                  perr_flag_q, perr_flag_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;

    logic start_seen;
    logic bit_sample;

    assign start_seen = sample_tick && !rx_in;
    assign bit_sample = sample_tick && (tick_q == TICK_LAST);

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            pen_q       <= 1'b0;
            podd_q      <= 1'b0;
            perr_flag_q <= 1'b0;
            data_out_q  <= '0;
            dv_q        <= 1'b0;
            perr_q      <= 1'b0;
            serr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pen_q       <= pen_d;
            podd_q      <= podd_d;
            perr_flag_q <= perr_flag_d;
            data_out_q  <= data_out_d;
            dv_q        <= dv_d;
            perr_q      <= perr_d;
            serr_q      <= serr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_seen) state_d = START;
            START:     if (sample_tick && (tick_q == TICK_MID)) state_d = START_CHK;
            START_CHK: state_d = start_bit_error ? IDLE : DATA;
            DATA:      if (bit_sample && (bit_q == BIT_LAST)) state_d = pen_q ? PARITY : STOP;
            PARITY:    if (bit_sample) state_d = STOP;
            STOP:      if (bit_sample) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pen_d       = pen_q;
        podd_d      = podd_q;
        perr_flag_d = perr_flag_q;
        data_out_d  = data_out_q;
        dv_d        = 1'b0;
        perr_d      = perr_q;
        serr_d      = serr_q;
        if (sample_tick && (state_q inside {DATA, PARITY, STOP})) begin
            tick_d = bit_sample ? '0 : tick_q + TW'(1);
        end
        case (state_q)
            IDLE: begin
                if (start_seen) begin
                    tick_d      = '0;
                    bit_d       = '0;
                    shift_d     = '0;
                    pen_d       = parity_en;
                    podd_d      = parity_odd;
                    perr_flag_d = 1'b0;
                end
            end
            START: begin
                if (sample_tick) tick_d = (tick_q == TICK_MID) ? '0 : tick_q + TW'(1);
            end
            START_CHK: begin
                // a tick landing here already counts toward the first data bit
                tick_d = sample_tick ? TW'(1) : '0;
                bit_d  = '0;
            end
            DATA: begin
                if (bit_sample) begin
                    shift_d[bit_q] = rx_in;
                    bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
                end
            end
            PARITY: begin
                if (bit_sample) perr_flag_d = rx_in != ((^shift_q) ^ podd_q);
            end
            STOP: begin
                if (bit_sample) begin
                    dv_d       = 1'b1;
                    data_out_d = shift_q;
                    perr_d     = perr_flag_q;
                    serr_d     = !rx_in;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        start_chk_en  = (state_q == START) && sample_tick && (tick_q == TICK_MID);
        start_chk_bit = start_chk_en && rx_in;
        busy          = (state_q != IDLE);
    end

    assign data_out     = data_out_q;
    assign data_valid   = dv_q;
    assign parity_error = perr_q;
    assign stop_error   = serr_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive frame controller. Sequences one serial frame (start, data, optional parity, stop) on a 16x-oversampling tick. Drives the start-bit checker through a one-cycle enable/sampled-bit handshake and consumes its registered error flag. Assembles the data word and reports frame status to the APB-side receive buffer.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=4)

Ports:
UCLK  input  1  receiver clock
reset  input  1  asynchronous active-low reset
sample_tick  input  1  one-UCLK pulse at OVERSAMPLE x baud
rx_in  input  1  synchronized serial line, idle high
parity_en  input  1  1 = frame carries parity bit
parity_odd  input  1  1 = odd parity, 0 = even
start_chk_en  output  1  enable to start-bit checker, one-cycle pulse
start_chk_bit  output  1  mid-bit sample of start bit, valid while start_chk_en=1
start_bit_error  input  1  checker result, valid the cycle after start_chk_en
data_out  output  DATA_WIDTH  received word, held until next frame completes
data_valid  output  1  one-cycle pulse, frame complete
parity_error  output  1  status of last frame, updated with data_valid
stop_error  output  1  status of last frame, updated with data_valid
busy  output  1  1 in any state except IDLE

Behaviour:
- Reset (async, reset=0): state IDLE; tick_cnt, bit_cnt, shift register cleared; data_out=0; data_valid, parity_error, stop_error, start_chk_en, start_chk_bit, busy all 0. Partial frame discarded; no data_valid.
- All transitions on posedge UCLK. tick_cnt advances only on sample_tick.
- States: IDLE, START, START_CHK, DATA, PARITY, STOP.
- IDLE: on sample_tick with rx_in=0, go to START, tick_cnt=0. Latch parity_en and parity_odd; mid-frame config changes are ignored.
- START: on the sample_tick where tick_cnt==OVERSAMPLE/2-1, drive start_chk_en=1 and start_chk_bit=rx_in for exactly that cycle, then go to START_CHK.
- START_CHK: lasts exactly one UCLK and samples start_bit_error.
  - 1: return to IDLE silently (glitch); no data_valid, status outputs unchanged.
  - 0: go to DATA with tick_cnt=0, bit_cnt=0.
  - A sample_tick arriving in this cycle still increments tick_cnt.
- Bit sampling: in DATA, PARITY and STOP, sample rx_in on the sample_tick where tick_cnt==OVERSAMPLE-1 (mid-bit), then wrap tick_cnt to 0.
- DATA: shift the sample in LSB-first at bit index bit_cnt. After DATA_WIDTH samples, go to PARITY if the latched parity_en=1, else STOP.
- PARITY: expected bit = XOR of data bits, inverted when parity_odd=1. The parity error flag is 1 if the sampled bit differs from the expected bit.
- STOP: stop error flag is 1 if the sampled bit is 0. On the cycle after the stop sample:
  - data_valid=1 for one cycle; data_out loaded.
  - parity_error and stop_error loaded (parity_error=0 when parity is disabled).
  - Return to IDLE.
- Frame with stop_error is still delivered (data_valid=1). Back-to-back frames: IDLE may detect a new start on the very next sample_tick.
- start_chk_en never asserts outside START. busy=0 only in IDLE.
- Latency: data_valid rises 1 UCLK after the mid-stop-bit sample_tick.

Test Plan:
- Byte 0xA5, 8N1, clean line -> one data_valid pulse, data_out=0xA5, parity_error=0, stop_error=0; start_chk_en pulses exactly once.
- rx_in low for 4 ticks then high (glitch), start_bit_error returned 1 -> back to IDLE, busy falls, no data_valid, data_out unchanged.
- Byte 0x03, parity_en=1, parity_odd=0, wrong parity bit=1 -> data_out=0x03, parity_error=1; repeat with correct bit=0 -> parity_error=0.
- Byte 0x5A, stop bit driven 0 -> data_valid=1, data_out=0x5A, stop_error=1.
- Assert reset during bit 4 of a frame -> all outputs 0 immediately; next clean 0x3C frame received correctly.
- Two back-to-back 0xFF/0x00 frames with no idle gap; toggle parity_en mid-frame -> two data_valid pulses with correct data, first frame uses latched config.
